// File: rtl/nvme_axil_reg_slave_if.sv
// nvme_axil_reg_slave_if: AXI4-Lite bus bundle between an AXI master and the register slave.
interface nvme_axil_reg_slave_if #(
    parameter int ADDR_BITS = 32
);
    logic [ADDR_BITS-1:0] awaddr;
    logic [2:0]           awprot;
    logic                 awvalid;
    logic                 awready;
    logic [31:0]          wdata;
    logic [3:0]           wstrb;
    logic                 wvalid;
    logic                 wready;
    logic [1:0]           bresp;
    logic                 bvalid;
    logic                 bready;
    logic [ADDR_BITS-1:0] araddr;
    logic [2:0]           arprot;
    logic                 arvalid;
    logic                 arready;
    logic [31:0]          rdata;
    logic [1:0]           rresp;
    logic                 rvalid;
    logic                 rready;

    modport slave (
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );
endinterface

// File: rtl/nvme_axil_reg_slave.sv
// nvme_axil_reg_slave: AXI4-Lite slave turning bus writes/reads into local strobe/ack register accesses.
// Define NVME_AXIL_TIMEOUT_EN to add a per-FSM ack timeout that answers SLVERR (reads return all ones).
module nvme_axil_reg_slave #(
    parameter int ADDR_BITS      = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 axi_aclk,
    input  logic                 axi_aresetn,
    nvme_axil_reg_slave_if.slave s_axi,
    output logic                 reg_wr,
    output logic [ADDR_BITS-1:0] reg_waddr,
    output logic [31:0]          reg_wdata,
    output logic [3:0]           reg_wstrb,
    input  logic                 reg_wack,
    input  logic                 reg_werr,
    output logic                 reg_rd,
    output logic [ADDR_BITS-1:0] reg_raddr,
    input  logic [31:0]          reg_rdata,
    input  logic                 reg_rack,
    input  logic                 reg_rerr
);
    typedef enum logic [1:0] {W_IDLE, W_REQ, W_WAIT, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_REQ, R_WAIT, R_RESP} r_state_e;

    w_state_e             w_state_q, w_state_d;
    r_state_e             r_state_q, r_state_d;
    logic                 aw_got_q, aw_got_d, w_got_q, w_got_d;
    logic                 awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
    logic                 w_ack_q, w_ack_d, r_ack_q, r_ack_d;
    logic [ADDR_BITS-1:0] waddr_q, waddr_d, raddr_q, raddr_d;
    logic [31:0]          wdata_q, wdata_d, rdata_q, rdata_d;
    logic [3:0]           wstrb_q, wstrb_d;
    logic [1:0]           bresp_q, bresp_d, rresp_q, rresp_d;
    logic                 aw_hs, w_hs, ar_hs, w_timeout, r_timeout;
    logic                 unused_ok;

    assign aw_hs = awready_q & s_axi.awvalid;
    assign w_hs  = wready_q & s_axi.wvalid;
    assign ar_hs = arready_q & s_axi.arvalid;

    assign s_axi.awready = awready_q;
    assign s_axi.wready  = wready_q;
    assign s_axi.arready = arready_q;
    assign s_axi.bvalid  = (w_state_q == W_RESP);
    assign s_axi.bresp   = bresp_q;
    assign s_axi.rvalid  = (r_state_q == R_RESP);
    assign s_axi.rresp   = rresp_q;
    assign s_axi.rdata   = rdata_q;
    assign reg_wr        = (w_state_q == W_REQ);
    assign reg_waddr     = waddr_q;
    assign reg_wdata     = wdata_q;
    assign reg_wstrb     = wstrb_q;
    assign reg_rd        = (r_state_q == R_REQ);
    assign reg_raddr     = raddr_q;
    assign unused_ok     = &{1'b0, s_axi.awprot, s_axi.arprot, 16'(TIMEOUT_CYCLES)};

`ifdef NVME_AXIL_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d;

    assign wcnt_d    = (w_state_q == W_REQ || w_state_q == W_WAIT) ? wcnt_q + 16'd1 : 16'd0;
    assign rcnt_d    = (r_state_q == R_REQ || r_state_q == R_WAIT) ? rcnt_q + 16'd1 : 16'd0;
    assign w_timeout = (wcnt_q >= TO_LAST);
    assign r_timeout = (rcnt_q >= TO_LAST);

    // Cycle counters measured from the strobe cycle (which counts as zero)
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            wcnt_q <= '0;
            rcnt_q <= '0;
        end else begin
            wcnt_q <= wcnt_d;
            rcnt_q <= rcnt_d;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign r_timeout = 1'b0;
`endif

    // Write FSM next state: collect AW and W in any order, strobe, wait for ack, respond
    always_comb begin
        w_state_d = w_state_q;
        aw_got_d  = aw_got_q;
        w_got_d   = w_got_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bresp_d   = bresp_q;
        w_ack_d   = w_ack_q;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_got_d = 1'b1;
                    waddr_d  = s_axi.awaddr;
                end
                if (w_hs) begin
                    w_got_d = 1'b1;
                    wdata_d = s_axi.wdata;
                    wstrb_d = s_axi.wstrb;
                end
                if (aw_got_d && w_got_d) begin
                    w_state_d = W_REQ;
                    aw_got_d  = 1'b0;
                    w_got_d   = 1'b0;
                end
            end
            W_REQ: begin
                w_state_d = W_WAIT;
                w_ack_d   = reg_wack;
                if (reg_wack) bresp_d = reg_werr ? 2'b10 : 2'b00;
            end
            W_WAIT: begin
                if (w_ack_q) begin
                    w_state_d = W_RESP;
                end else if (reg_wack) begin
                    w_state_d = W_RESP;
                    bresp_d   = reg_werr ? 2'b10 : 2'b00;
                end else if (w_timeout) begin
                    w_state_d = W_RESP;
                    bresp_d   = 2'b10;
                end
            end
            W_RESP: if (s_axi.bready) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
        awready_d = (w_state_d == W_IDLE) && !aw_got_d;
        wready_d  = (w_state_d == W_IDLE) && !w_got_d;
    end

    // Read FSM next state: capture address, strobe, wait for ack, return data
    always_comb begin
        r_state_d = r_state_q;
        raddr_d   = raddr_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        r_ack_d   = r_ack_q;
        case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    raddr_d   = s_axi.araddr;
                    r_state_d = R_REQ;
                end
            end
            R_REQ: begin
                r_state_d = R_WAIT;
                r_ack_d   = reg_rack;
                if (reg_rack) begin
                    rdata_d = reg_rdata;
                    rresp_d = reg_rerr ? 2'b10 : 2'b00;
                end
            end
            R_WAIT: begin
                if (r_ack_q) begin
                    r_state_d = R_RESP;
                end else if (reg_rack) begin
                    r_state_d = R_RESP;
                    rdata_d   = reg_rdata;
                    rresp_d   = reg_rerr ? 2'b10 : 2'b00;
                end else if (r_timeout) begin
                    r_state_d = R_RESP;
                    rdata_d   = 32'hFFFF_FFFF;
                    rresp_d   = 2'b10;
                end
            end
            R_RESP: if (s_axi.rready) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
        arready_d = (r_state_d == R_IDLE);
    end

    // State and datapath registers; reset abandons any transaction in flight
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            arready_q <= 1'b0;
            w_ack_q   <= 1'b0;
            r_ack_q   <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bresp_q   <= '0;
            raddr_q   <= '0;
            rdata_q   <= '0;
            rresp_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            aw_got_q  <= aw_got_d;
            w_got_q   <= w_got_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            arready_q <= arready_d;
            w_ack_q   <= w_ack_d;
            r_ack_q   <= r_ack_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bresp_q   <= bresp_d;
            raddr_q   <= raddr_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end
endmodule

// File: tb/tb_nvme_axil_reg_slave.sv
// tb_nvme_axil_reg_slave: directed self-checking bench for the AXI-Lite register slave.
module tb_nvme_axil_reg_slave;
    logic        clk = 1'b0;
    logic        rstn;
    logic        reg_wr, reg_rd;
    logic [31:0] reg_waddr, reg_wdata, reg_raddr, reg_rdata;
    logic [3:0]  reg_wstrb;
    logic        reg_wack, reg_werr, reg_rack, reg_rerr;
    int          checks = 0;
    int          errors = 0;
    int          wr_pulses = 0;
    int          rd_pulses = 0;

    always #5 clk = ~clk;

    nvme_axil_reg_slave_if #(.ADDR_BITS(32)) axi ();

    nvme_axil_reg_slave #(.ADDR_BITS(32), .TIMEOUT_CYCLES(8)) dut (
        .axi_aclk    (clk),
        .axi_aresetn (rstn),
        .s_axi       (axi),
        .reg_wr      (reg_wr),
        .reg_waddr   (reg_waddr),
        .reg_wdata   (reg_wdata),
        .reg_wstrb   (reg_wstrb),
        .reg_wack    (reg_wack),
        .reg_werr    (reg_werr),
        .reg_rd      (reg_rd),
        .reg_raddr   (reg_raddr),
        .reg_rdata   (reg_rdata),
        .reg_rack    (reg_rack),
        .reg_rerr    (reg_rerr)
    );

    always @(posedge clk) begin
        if (reg_wr) wr_pulses++;
        if (reg_rd) rd_pulses++;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        axi.awaddr = '0; axi.awprot = '0; axi.awvalid = 0; axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 0;
        axi.bready = 0; axi.araddr = '0; axi.arprot = '0; axi.arvalid = 0; axi.rready = 0;
        reg_wack = 0; reg_werr = 0; reg_rack = 0; reg_rerr = 0; reg_rdata = '0;
        repeat (3) tick();
        checks++;
        if ({axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid, reg_wr, reg_rd} !== 7'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b want 0000000", {axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid, reg_wr, reg_rd});
        end
        checks++;
        if ({axi.bresp, axi.rresp, axi.rdata, reg_waddr, reg_wdata, reg_wstrb, reg_raddr} !== 136'd0) begin
            errors++; $display("FAIL reset_data: got %h want 0", {axi.bresp, axi.rresp, axi.rdata, reg_waddr, reg_wdata, reg_wstrb, reg_raddr});
        end
        rstn = 1'b1;
        tick();
        checks++;
        if ({axi.awready, axi.wready, axi.arready} !== 3'b111) begin
            errors++; $display("FAIL reset_release_ready: got %b want 111", {axi.awready, axi.wready, axi.arready});
        end
    endtask

    task automatic test_write_aw_first();
        int p0 = wr_pulses;
        axi.awaddr = 32'h10; axi.awvalid = 1;
        tick();
        axi.awvalid = 0;
        checks++;
        if ({axi.awready, axi.wready} !== 2'b01) begin
            errors++; $display("FAIL aw_first_ready: got %b want 01", {axi.awready, axi.wready});
        end
        axi.wdata = 32'hA5A5_A5A5; axi.wstrb = 4'hF; axi.wvalid = 1;
        tick();
        axi.wvalid = 0;
        checks++;
        if (reg_wr !== 1'b1) begin errors++; $display("FAIL aw_first_strobe: got %b want 1", reg_wr); end
        checks++;
        if ({reg_waddr, reg_wdata, reg_wstrb} !== {32'h10, 32'hA5A5_A5A5, 4'hF}) begin
            errors++; $display("FAIL aw_first_payload: got %h want %h", {reg_waddr, reg_wdata, reg_wstrb}, {32'h10, 32'hA5A5_A5A5, 4'hF});
        end
        tick();
        checks++;
        if ({reg_wr, axi.bvalid} !== 2'b00) begin errors++; $display("FAIL aw_first_wait: got %b want 00", {reg_wr, axi.bvalid}); end
        tick();
        reg_wack = 1;
        tick();
        reg_wack = 0;
        checks++;
        if ({axi.bvalid, axi.bresp} !== 3'b100) begin errors++; $display("FAIL aw_first_bresp: got %b want 100", {axi.bvalid, axi.bresp}); end
        checks++;
        if ({reg_waddr, reg_wdata} !== {32'h10, 32'hA5A5_A5A5}) begin
            errors++; $display("FAIL aw_first_hold: got %h want %h", {reg_waddr, reg_wdata}, {32'h10, 32'hA5A5_A5A5});
        end
        axi.bready = 1;
        tick();
        axi.bready = 0;
        checks++;
        if ({axi.bvalid, axi.awready, axi.wready} !== 3'b011) begin
            errors++; $display("FAIL aw_first_done: got %b want 011", {axi.bvalid, axi.awready, axi.wready});
        end
        checks++;
        if (wr_pulses - p0 !== 1) begin errors++; $display("FAIL aw_first_pulses: got %0d want 1", wr_pulses - p0); end
    endtask

    task automatic test_write_w_first_err();
        axi.wdata = 32'h0000_BEEF; axi.wstrb = 4'h3; axi.wvalid = 1;
        tick();
        axi.wvalid = 0;
        checks++;
        if ({axi.awready, axi.wready} !== 2'b10) begin
            errors++; $display("FAIL w_first_ready: got %b want 10", {axi.awready, axi.wready});
        end
        axi.awaddr = 32'h1C; axi.awvalid = 1;
        tick();
        axi.awvalid = 0;
        checks++;
        if ({reg_wr, reg_waddr, reg_wdata, reg_wstrb} !== {1'b1, 32'h1C, 32'h0000_BEEF, 4'h3}) begin
            errors++; $display("FAIL w_first_strobe: got %h want %h", {reg_wr, reg_waddr, reg_wdata, reg_wstrb}, {1'b1, 32'h1C, 32'h0000_BEEF, 4'h3});
        end
        reg_wack = 1; reg_werr = 1;
        tick();
        reg_wack = 0; reg_werr = 0;
        checks++;
        if (axi.bvalid !== 1'b0) begin errors++; $display("FAIL w_first_early: got %b want 0", axi.bvalid); end
        tick();
        checks++;
        if ({axi.bvalid, axi.bresp} !== 3'b110) begin errors++; $display("FAIL w_first_bresp: got %b want 110", {axi.bvalid, axi.bresp}); end
        axi.bready = 1;
        tick();
        axi.bready = 0;
    endtask

    task automatic test_read_err();
        int p0 = rd_pulses;
        axi.araddr = 32'h20; axi.arvalid = 1;
        tick();
        axi.arvalid = 0;
        checks++;
        if ({reg_rd, axi.arready, reg_raddr} !== {2'b10, 32'h20}) begin
            errors++; $display("FAIL read_strobe: got %h want %h", {reg_rd, axi.arready, reg_raddr}, {2'b10, 32'h20});
        end
        reg_rack = 1; reg_rerr = 1; reg_rdata = 32'h1234_5678;
        tick();
        reg_rack = 0; reg_rerr = 0; reg_rdata = '0;
        checks++;
        if ({reg_rd, axi.rvalid} !== 2'b00) begin errors++; $display("FAIL read_wait: got %b want 00", {reg_rd, axi.rvalid}); end
        tick();
        checks++;
        if ({axi.rvalid, axi.rresp, axi.rdata} !== {3'b110, 32'h1234_5678}) begin
            errors++; $display("FAIL read_resp: got %h want %h", {axi.rvalid, axi.rresp, axi.rdata}, {3'b110, 32'h1234_5678});
        end
        axi.rready = 1;
        tick();
        axi.rready = 0;
        checks++;
        if ({axi.rvalid, axi.arready} !== 2'b01) begin errors++; $display("FAIL read_done: got %b want 01", {axi.rvalid, axi.arready}); end
        checks++;
        if (rd_pulses - p0 !== 1) begin errors++; $display("FAIL read_pulses: got %0d want 1", rd_pulses - p0); end
    endtask

    task automatic test_stray_ack();
        reg_wack = 1; reg_rack = 1;
        tick();
        reg_wack = 0; reg_rack = 0;
        tick();
        checks++;
        if ({axi.bvalid, axi.rvalid, axi.awready, axi.arready} !== 4'b0011) begin
            errors++; $display("FAIL stray_ack: got %b want 0011", {axi.bvalid, axi.rvalid, axi.awready, axi.arready});
        end
    endtask

    task automatic test_back_to_back();
        axi.awaddr = 32'h04; axi.awvalid = 1; axi.wdata = 32'hDEAD_BEEF; axi.wstrb = 4'h3; axi.wvalid = 1;
        axi.araddr = 32'h08; axi.arvalid = 1;
        tick();
        axi.awvalid = 0; axi.wvalid = 0; axi.arvalid = 0;
        checks++;
        if ({reg_wr, reg_rd, reg_waddr, reg_raddr} !== {2'b11, 32'h04, 32'h08}) begin
            errors++; $display("FAIL concurrent_strobe: got %h want %h", {reg_wr, reg_rd, reg_waddr, reg_raddr}, {2'b11, 32'h04, 32'h08});
        end
        reg_wack = 1; reg_rack = 1; reg_rdata = 32'hCAFE_F00D;
        tick();
        reg_wack = 0; reg_rack = 0; reg_rdata = '0;
        tick();
        checks++;
        if ({axi.bvalid, axi.rvalid, axi.bresp, axi.rresp, axi.rdata} !== {6'b110000, 32'hCAFE_F00D}) begin
            errors++; $display("FAIL concurrent_resp: got %h want %h", {axi.bvalid, axi.rvalid, axi.bresp, axi.rresp, axi.rdata}, {6'b110000, 32'hCAFE_F00D});
        end
        axi.bready = 1;
        tick();
        axi.bready = 0;
        checks++;
        if ({axi.bvalid, axi.awready} !== 2'b01) begin errors++; $display("FAIL concurrent_write_done: got %b want 01", {axi.bvalid, axi.awready}); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({axi.rvalid, axi.rresp, axi.rdata} !== {3'b100, 32'hCAFE_F00D}) begin
                errors++; $display("FAIL concurrent_stall%0d: got %h want %h", i, {axi.rvalid, axi.rresp, axi.rdata}, {3'b100, 32'hCAFE_F00D});
            end
            tick();
        end
        axi.rready = 1;
        tick();
        axi.rready = 0;
        checks++;
        if ({axi.rvalid, axi.arready} !== 2'b01) begin errors++; $display("FAIL concurrent_read_done: got %b want 01", {axi.rvalid, axi.arready}); end
    endtask

`ifdef NVME_AXIL_TIMEOUT_EN
    task automatic test_timeout();
        axi.araddr = 32'h30; axi.arvalid = 1;
        tick();
        axi.arvalid = 0;
        repeat (7) tick();
        checks++;
        if (axi.rvalid !== 1'b0) begin errors++; $display("FAIL timeout_early: got %b want 0", axi.rvalid); end
        tick();
        checks++;
        if ({axi.rvalid, axi.rresp, axi.rdata} !== {3'b110, 32'hFFFF_FFFF}) begin
            errors++; $display("FAIL timeout_resp: got %h want %h", {axi.rvalid, axi.rresp, axi.rdata}, {3'b110, 32'hFFFF_FFFF});
        end
        repeat (3) tick();
        reg_rack = 1; reg_rdata = 32'h1111_1111;
        tick();
        reg_rack = 0; reg_rdata = '0;
        checks++;
        if ({axi.rvalid, axi.rresp, axi.rdata} !== {3'b110, 32'hFFFF_FFFF}) begin
            errors++; $display("FAIL timeout_late_ack: got %h want %h", {axi.rvalid, axi.rresp, axi.rdata}, {3'b110, 32'hFFFF_FFFF});
        end
        axi.rready = 1;
        tick();
        axi.rready = 0;
        tick();
        checks++;
        if ({axi.rvalid, axi.arready} !== 2'b01) begin errors++; $display("FAIL timeout_done: got %b want 01", {axi.rvalid, axi.arready}); end
    endtask
`else
    task automatic test_no_timeout();
        axi.araddr = 32'h30; axi.arvalid = 1;
        tick();
        axi.arvalid = 0;
        repeat (20) tick();
        checks++;
        if (axi.rvalid !== 1'b0) begin errors++; $display("FAIL no_timeout_wait: got %b want 0", axi.rvalid); end
        reg_rack = 1; reg_rdata = 32'h5A5A_0001;
        tick();
        reg_rack = 0; reg_rdata = '0;
        tick();
        checks++;
        if ({axi.rvalid, axi.rresp, axi.rdata} !== {3'b100, 32'h5A5A_0001}) begin
            errors++; $display("FAIL no_timeout_resp: got %h want %h", {axi.rvalid, axi.rresp, axi.rdata}, {3'b100, 32'h5A5A_0001});
        end
        axi.rready = 1;
        tick();
        axi.rready = 0;
    endtask
`endif

    task automatic test_reset_mid();
        axi.awaddr = 32'h40; axi.awvalid = 1; axi.wdata = 32'h1122_3344; axi.wstrb = 4'hF; axi.wvalid = 1;
        tick();
        axi.awvalid = 0; axi.wvalid = 0;
        checks++;
        if (reg_wr !== 1'b1) begin errors++; $display("FAIL mid_strobe: got %b want 1", reg_wr); end
        tick();
        rstn = 1'b0;
        #1;
        checks++;
        if ({axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid, reg_wr, reg_rd} !== 7'b0) begin
            errors++; $display("FAIL mid_reset_ctrl: got %b want 0000000", {axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid, reg_wr, reg_rd});
        end
        checks++;
        if ({axi.bresp, axi.rresp, axi.rdata, reg_waddr, reg_wdata, reg_wstrb, reg_raddr} !== 136'd0) begin
            errors++; $display("FAIL mid_reset_data: got %h want 0", {axi.bresp, axi.rresp, axi.rdata, reg_waddr, reg_wdata, reg_wstrb, reg_raddr});
        end
        tick();
        rstn = 1'b1;
        tick();
        checks++;
        if ({axi.awready, axi.wready, axi.arready} !== 3'b111) begin
            errors++; $display("FAIL mid_release_ready: got %b want 111", {axi.awready, axi.wready, axi.arready});
        end
        reg_wack = 1;
        tick();
        reg_wack = 0;
        checks++;
        if (axi.bvalid !== 1'b0) begin errors++; $display("FAIL mid_abandoned: got %b want 0", axi.bvalid); end
    endtask

    initial begin
        test_reset();
        test_write_aw_first();
        test_write_w_first_err();
        test_read_err();
        test_stray_ack();
        test_back_to_back();
`ifdef NVME_AXIL_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/nvme_axil_reg_slave.md
NVME_AXIL_REG_SLAVE -- requirements
Module: nvme_axil_reg_slave

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 32, width of the AXI-Lite and local addresses.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, cycles to wait for a local acknowledge before an error response (range 1..65535).
REQ-003 SHALL have port axi_aclk  in  1  clock; all logic on the rising edge.
REQ-004 SHALL have port axi_aresetn  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports s_axi_awaddr in ADDR_BITS, s_axi_awprot in 3 (ignored), s_axi_awvalid in 1 and s_axi_awready out 1, forming the write-address channel.
REQ-006 SHALL have ports s_axi_wdata in 32, s_axi_wstrb in 4, s_axi_wvalid in 1 and s_axi_wready out 1, forming the write-data channel.
REQ-007 SHALL have ports s_axi_bresp out 2, s_axi_bvalid out 1 and s_axi_bready in 1, forming the write-response channel.
REQ-008 SHALL have ports s_axi_araddr in ADDR_BITS, s_axi_arprot in 3 (ignored), s_axi_arvalid in 1 and s_axi_arready out 1, forming the read-address channel.
REQ-009 SHALL have ports s_axi_rdata out 32, s_axi_rresp out 2, s_axi_rvalid out 1 and s_axi_rready in 1, forming the read-data channel.
REQ-010 SHALL have local write ports reg_wr out 1, reg_waddr out ADDR_BITS, reg_wdata out 32, reg_wstrb out 4, reg_wack in 1 and reg_werr in 1.
REQ-011 SHALL have local read ports reg_rd out 1, reg_raddr out ADDR_BITS, reg_rdata in 32, reg_rack in 1 and reg_rerr in 1.

Function
REQ-012 The write FSM SHALL use states W_IDLE, W_REQ, W_WAIT and W_RESP; the read FSM SHALL use states R_IDLE, R_REQ, R_WAIT and R_RESP; the two FSMs SHALL run independently and concurrently.
REQ-013 In W_IDLE, awready and wready SHALL each be high until their own beat is captured; AW and W may arrive in either order or in the same cycle, and each SHALL be captured exactly once.
REQ-014 Once both AW and W are captured, the FSM SHALL enter W_REQ and drive reg_wr high for exactly 1 cycle, with reg_waddr, reg_wdata and reg_wstrb held stable from that cycle until W_RESP exits.
REQ-015 In W_WAIT, reg_wack SHALL move the FSM to W_RESP with bvalid=1 the next cycle, and bresp SHALL be 2'b10 if reg_werr is set, else 2'b00.
REQ-016 bvalid and bresp SHALL hold until bready; on the handshake the FSM SHALL return to W_IDLE, and awready and wready SHALL reassert on the following cycle.
REQ-017 In R_IDLE, arready SHALL be 1; on arvalid the address SHALL be captured, arready SHALL drop, and the FSM SHALL enter R_REQ with reg_rd high for exactly 1 cycle.
REQ-018 In R_WAIT, reg_rack SHALL move the FSM to R_RESP with rvalid=1, rdata=reg_rdata and rresp=2'b10 if reg_rerr is set, else 2'b00.
REQ-019 rvalid, rdata and rresp SHALL hold until rready; on the handshake the FSM SHALL return to R_IDLE.
REQ-020 An ack arriving in the same cycle as the reg_wr or reg_rd strobe SHALL be accepted; an ack received in any state other than W_WAIT/R_WAIT or W_REQ/R_REQ SHALL be ignored.
REQ-021 At most one write and one read SHALL be outstanding; best case, AW+W to bvalid is 3 cycles and AR to rvalid is 3 cycles with ack in the strobe cycle.

Reset
REQ-022 While axi_aresetn is low, every output SHALL be 0 (awready, wready, arready, bvalid, rvalid, reg_wr, reg_rd, bresp, rresp, rdata, reg_waddr, reg_wdata, reg_wstrb, reg_raddr), and both FSMs SHALL be in IDLE.
REQ-023 A reset mid-transaction SHALL abandon it with no response; the ready signals SHALL assert on the first clock after reset release.

Configuration
REQ-024 With macro NVME_AXIL_TIMEOUT_EN defined, a 16-bit per-FSM counter SHALL start at the strobe cycle; if no ack arrives within TIMEOUT_CYCLES cycles, the FSM SHALL respond with resp=2'b10 (read: rdata=32'hFFFFFFFF), and a later ack SHALL be ignored.
REQ-025 Without NVME_AXIL_TIMEOUT_EN, no counter SHALL exist and W_WAIT/R_WAIT SHALL wait indefinitely.

Verification
REQ-026 The bench SHALL cover: AW addr 0x10 one cycle before W data 0xA5A5A5A5, wack 2 cycles after strobe -> one reg_wr pulse, addr 0x10/data 0xA5A5A5A5, bresp 00.
REQ-027 The bench SHALL cover: AR 0x20 with rack+rerr in the strobe cycle, rdata 0x12345678 -> rvalid 3 cycles after AR, rresp 10, rdata 0x12345678.
REQ-028 The bench SHALL cover: simultaneous write 0x04 and read 0x08 with rready low for 5 cycles -> both complete independently, and rvalid/rdata stay stable for the 5 stall cycles.
REQ-029 The bench SHALL cover, with NVME_AXIL_TIMEOUT_EN defined and TIMEOUT_CYCLES=8: a read with no rack -> rresp 10, rdata 0xFFFFFFFF, and a rack on cycle 12 ignored.
REQ-030 The bench SHALL cover: reset asserted in W_WAIT -> all outputs 0 at once, and awready=1 one cycle after release.
